// File: rtl/meteo_display_sequencer_if.sv
// Signal bundle between the sensor side (master) and meteo_display_sequencer (slave).
interface meteo_display_sequencer_if #(
    parameter int NCH  = 3,
    parameter int DW   = 32,
    parameter int NDIG = 8,
    parameter int CW   = 2
);
    logic [NCH*DW-1:0] Data_i;
    logic [NCH-1:0]    Valid_i;
    logic              Tick_i;
    logic              Mode_i;
    logic [CW-1:0]     Sel_i;
    logic [4*NDIG-1:0] Bcd_o;
    logic [CW-1:0]     Chan_o;
    logic              BcdValid_o;
    logic              Busy_o;
    logic              Ovf_o;
    logic              Neg_o;

    modport master (
        output Data_i, Valid_i, Tick_i, Mode_i, Sel_i,
        input  Bcd_o, Chan_o, BcdValid_o, Busy_o, Ovf_o, Neg_o
    );

    modport slave (
        input  Data_i, Valid_i, Tick_i, Mode_i, Sel_i,
        output Bcd_o, Chan_o, BcdValid_o, Busy_o, Ovf_o, Neg_o
    );
endinterface

// File: rtl/meteo_display_sequencer.sv
// Multi-channel hold + manual/auto channel select + sequential double-dabble BCD converter.
// Optional two's-complement channel values: define METEO_DISP_SIGNED_EN.
module meteo_display_sequencer #(
    parameter int NCH          = 3,
    parameter int DW           = 32,
    parameter int NDIG         = 8,
    parameter int CW           = 2,
    parameter int SCROLL_TICKS = 4
) (
    input  logic                    Clk_i,
    input  logic                    Rst_i,
    meteo_display_sequencer_if.slave bus
);
    localparam int SW = $clog2(SCROLL_TICKS + 1);
    localparam int KW = $clog2(DW + 1);
    localparam int BW = 4 * NDIG;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t        r_state;
    logic [DW-1:0] r_hold [NCH];
    logic [CW-1:0] r_cur_ch;
    logic [CW-1:0] r_conv_ch;
    logic [SW-1:0] r_scroll;
    logic          r_mode_q;
    logic          r_dirty;
    logic [DW-1:0] r_src;
    logic [BW-1:0] r_bcd;
    logic [KW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_neg;

    logic [BW-1:0] r_bcd_o;
    logic [CW-1:0] r_chan_o;
    logic          r_bcd_valid;
    logic          r_busy;
    logic          r_ovf_o;
    logic          r_neg_o;

    logic [CW-1:0] w_next_ch;
    logic [SW-1:0] w_next_scroll;
    logic          w_dirty_set;
    logic [BW-1:0] w_adj;
    logic [DW-1:0] w_sel_val;
    logic [DW-1:0] w_mag;
    logic          w_neg_in;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_ch     = r_cur_ch;
        w_next_scroll = r_scroll;
        if (bus.Mode_i != r_mode_q) begin
            w_next_scroll = '0;
        end else if (bus.Mode_i && bus.Tick_i) begin
            if (r_scroll == SW'(SCROLL_TICKS - 1)) begin
                w_next_scroll = '0;
                w_next_ch     = (r_cur_ch == CW'(NCH - 1)) ? '0 : r_cur_ch + CW'(1);
            end else begin
                w_next_scroll = r_scroll + SW'(1);
            end
        end
        if (!bus.Mode_i) begin
            w_next_ch = (int'(bus.Sel_i) >= NCH) ? CW'(NCH - 1) : bus.Sel_i;
        end
    end

    assign w_dirty_set = (w_next_ch != r_cur_ch) || bus.Valid_i[r_cur_ch];
    assign w_sel_val   = r_hold[r_cur_ch];

`ifdef METEO_DISP_SIGNED_EN
    // -x of the most negative value wraps to itself, which as unsigned is exactly 2^(DW-1).
    assign w_neg_in = w_sel_val[DW-1];
    assign w_mag    = w_neg_in ? (~w_sel_val + DW'(1)) : w_sel_val;
`else
    assign w_neg_in = 1'b0;
    assign w_mag    = w_sel_val;
`endif

    // NOTE: blocking '=' is correct here: w_adj is combinational, re-evaluated digit by digit.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < NDIG; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_state     <= S_IDLE;
            // NOTE: the hold array is reset on purpose: channel 0 must read as 0 after reset.
            for (int k = 0; k < NCH; k++) r_hold[k] <= '0;
            r_cur_ch    <= '0;
            r_conv_ch   <= '0;
            r_scroll    <= '0;
            r_mode_q    <= 1'b0;
            r_dirty     <= 1'b1;
            r_src       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_neg       <= 1'b0;
            r_bcd_o     <= '0;
            r_chan_o    <= '0;
            r_bcd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf_o     <= 1'b0;
            r_neg_o     <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (bus.Valid_i[k]) r_hold[k] <= bus.Data_i[k*DW +: DW];
            end
            r_cur_ch    <= w_next_ch;
            r_scroll    <= w_next_scroll;
            r_mode_q    <= bus.Mode_i;
            // A new event arriving in LOAD wins over the clear, forcing a re-conversion.
            r_dirty     <= (r_dirty && (r_state != S_LOAD)) || w_dirty_set;
            r_bcd_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_dirty) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_src     <= w_mag;
                    r_neg     <= w_neg_in;
                    r_conv_ch <= r_cur_ch;
                    r_bcd     <= '0;
                    r_ovf     <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    {r_bcd, r_src} <= {w_adj[BW-2:0], r_src, 1'b0};
                    r_ovf          <= r_ovf | w_adj[BW-1];
                    r_cnt          <= r_cnt + KW'(1);
                    if (r_cnt == KW'(DW - 1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_bcd_o     <= r_ovf ? {NDIG{4'h9}} : r_bcd;
                    r_chan_o    <= r_conv_ch;
                    r_ovf_o     <= r_ovf;
                    r_neg_o     <= r_neg;
                    r_bcd_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Bcd_o      = r_bcd_o;
    assign bus.Chan_o     = r_chan_o;
    assign bus.BcdValid_o = r_bcd_valid;
    assign bus.Busy_o     = r_busy;
    assign bus.Ovf_o      = r_ovf_o;
    assign bus.Neg_o      = r_neg_o;
endmodule

// File: tb/tb_meteo_display_sequencer.sv
// Self-checking bench for meteo_display_sequencer: table vectors, random values vs. a decimal model,
// and hand-written sequences for reset, auto-scroll, mid-conversion capture and 4-digit overflow.
module tb_meteo_display_sequencer;
    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int CW  = 2;
    localparam int ST  = 4;
    localparam int LAT = DW + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    meteo_display_sequencer_if #(.NCH(NCH), .DW(DW), .NDIG(8), .CW(CW)) bus ();
    meteo_display_sequencer_if #(.NCH(NCH), .DW(DW), .NDIG(4), .CW(CW)) bus4 ();

    meteo_display_sequencer #(
        .NCH(NCH), .DW(DW), .NDIG(8), .CW(CW), .SCROLL_TICKS(ST)
    ) u_dut (.Clk_i(clk), .Rst_i(rst), .bus(bus));

    meteo_display_sequencer #(
        .NCH(NCH), .DW(DW), .NDIG(4), .CW(CW), .SCROLL_TICKS(ST)
    ) u_dut4 (.Clk_i(clk), .Rst_i(rst), .bus(bus4));

    typedef struct { logic [31:0] bcd; logic ovf; logic neg; } exp_t;
    typedef struct { int ch; logic [31:0] value; logic [31:0] bcd; logic ovf; } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] hold_m [NCH];

    // Decimal reference: digits by repeated /10, saturate to all nines past 10^ndig-1.
    function automatic exp_t model(input logic [31:0] raw, input int ndig);
        exp_t   e;
        longint mag;
        longint lim;
        e.bcd = '0;
        e.neg = 1'b0;
        mag   = {32'd0, raw};
`ifdef METEO_DISP_SIGNED_EN
        if (raw[31]) begin
            e.neg = 1'b1;
            mag   = 64'd4294967296 - mag;
        end
`endif
        lim = 1;
        for (int i = 0; i < ndig; i++) lim = lim * 10;
        e.ovf = (mag >= lim);
        for (int d = 0; d < ndig; d++) begin
            e.bcd[4*d +: 4] = e.ovf ? 4'h9 : 4'(mag % 10);
            mag = mag / 10;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            step();
            cyc++;
            got = bus.BcdValid_o;
        end
    endtask

    task automatic count_valids(input int ncyc, output int n, output logic [CW-1:0] ch,
                                output logic [31:0] bcd);
        n   = 0;
        ch  = '0;
        bcd = '0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (bus.BcdValid_o) begin
                n++;
                ch  = bus.Chan_o;
                bcd = bus.Bcd_o;
            end
        end
    endtask

    task automatic settle();
        int quiet = 0;
        int cyc   = 0;
        while (quiet < 3 && cyc < 400) begin
            step();
            cyc++;
            quiet = bus.Busy_o ? 0 : quiet + 1;
        end
        check("settle_idle", 64'(quiet >= 3), 1);
    endtask

    task automatic do_conv(input string name, input int ch, input logic [31:0] value,
                           output bit got);
        int cyc;
        bus.Sel_i               = CW'(ch);
        bus.Data_i[ch*DW +: DW] = value;
        bus.Valid_i             = NCH'(1) << ch;
        hold_m[ch]              = value;
        step();
        bus.Valid_i = '0;
        wait_valid(LAT + 8, got, cyc);
        check({name, "_valid"}, 64'(got), 1);
        check({name, "_latency"}, 64'(cyc), 64'(LAT + 1));
    endtask

    task automatic conv4(input logic [31:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
        bit got;
        int cyc;
        bus4.Sel_i          = '0;
        bus4.Data_i[0 +: DW] = v;
        bus4.Valid_i        = 3'b001;
        step();
        bus4.Valid_i = '0;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < LAT + 8) begin
            step();
            cyc++;
            got = bus4.BcdValid_o;
        end
        check("ndig4_valid", 64'(got), 1);
        check("ndig4_bcd", 64'(bus4.Bcd_o), 64'(exp_bcd));
        check("ndig4_ovf", 64'(bus4.Ovf_o), 64'(exp_ovf));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [6];
        exp_t        e;
        bit          got;
        int          cyc;
        int          n;
        int          rch;
        int          exp_ch;
        logic [31:0] rval;
        logic [CW-1:0] ch_seen;
        logic [31:0] bcd_seen;

        vecs[0] = '{0, 32'd2315,      32'h0000_2315, 1'b0};
        vecs[1] = '{1, 32'd0,         32'h0000_0000, 1'b0};
        vecs[2] = '{2, 32'd99999999,  32'h9999_9999, 1'b0};
        vecs[3] = '{1, 32'd100000000, 32'h9999_9999, 1'b1};
        vecs[4] = '{2, 32'd10,        32'h0000_0010, 1'b0};
        vecs[5] = '{0, 32'd7,         32'h0000_0007, 1'b0};

        rst = 1'b1;
        bus.Data_i  = '0; bus.Valid_i  = '0; bus.Tick_i  = 1'b0; bus.Mode_i  = 1'b0; bus.Sel_i  = '0;
        bus4.Data_i = '0; bus4.Valid_i = '0; bus4.Tick_i = 1'b0; bus4.Mode_i = 1'b0; bus4.Sel_i = '0;
        for (int k = 0; k < NCH; k++) hold_m[k] = '0;

        // Reset state and the automatic conversion of channel 0 after release.
        repeat (3) step();
        check("rst_bcd", 64'(bus.Bcd_o), 0);
        check("rst_valid", 64'(bus.BcdValid_o), 0);
        check("rst_busy", 64'(bus.Busy_o), 0);
        check("rst_chan", 64'(bus.Chan_o), 0);
        check("rst_ovf_neg", 64'({bus.Ovf_o, bus.Neg_o}), 0);
        rst = 1'b0;
        cyc = 0;
        while (!bus.Busy_o && cyc < 5) begin
            step();
            cyc++;
        end
        check("rst_load_cycle", 64'(cyc), 1);
        wait_valid(LAT + 8, got, cyc);
        check("rst_conv_valid", 64'(got), 1);
        check("rst_conv_latency", 64'(cyc), 64'(LAT));
        check("rst_conv_bcd", 64'(bus.Bcd_o), 0);
        check("rst_conv_chan", 64'(bus.Chan_o), 0);
        check("rst_conv_ovf", 64'(bus.Ovf_o), 0);
        settle();

        // Table vectors, manual mode.
        for (int i = 0; i < 6; i++) begin
            do_conv($sformatf("vec%0d", i), vecs[i].ch, vecs[i].value, got);
            check($sformatf("vec%0d_bcd", i), 64'(bus.Bcd_o), 64'(vecs[i].bcd));
            check($sformatf("vec%0d_chan", i), 64'(bus.Chan_o), 64'(vecs[i].ch));
            check($sformatf("vec%0d_ovf", i), 64'(bus.Ovf_o), 64'(vecs[i].ovf));
            settle();
        end

        // Capture on a channel that is not displayed: no conversion.
        bus.Data_i[2*DW +: DW] = 32'd4242;
        bus.Valid_i            = 3'b100;
        hold_m[2]              = 32'd4242;
        step();
        bus.Valid_i = '0;
        count_valids(LAT + 8, n, ch_seen, bcd_seen);
        check("other_ch_no_conv", 64'(n), 0);

        // Sel_i beyond NCH-1 clamps to the last channel.
        bus.Sel_i = 2'd3;
        wait_valid(LAT + 8, got, cyc);
        check("clamp_valid", 64'(got), 1);
        check("clamp_chan", 64'(bus.Chan_o), 2);
        check("clamp_bcd", 64'(bus.Bcd_o), 64'(32'h0000_4242));
        settle();

        // Negative input pattern.
        do_conv("neg", 0, 32'hFFFF_FB2E, got);
`ifdef METEO_DISP_SIGNED_EN
        check("neg_bcd", 64'(bus.Bcd_o), 64'(32'h0000_1234));
        check("neg_flags", 64'({bus.Ovf_o, bus.Neg_o}), 64'(2'b01));
`else
        check("neg_bcd", 64'(bus.Bcd_o), 64'(32'h9999_9999));
        check("neg_flags", 64'({bus.Ovf_o, bus.Neg_o}), 64'(2'b10));
`endif
        settle();

        // Random values against the decimal model.
        for (int i = 0; i < 16; i++) begin
            rch  = $urandom_range(0, NCH - 1);
            rval = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 99999999));
            do_conv("rand", rch, rval, got);
            e = model(rval, 8);
            check("rand_bcd", 64'(bus.Bcd_o), 64'(e.bcd));
            check("rand_chan", 64'(bus.Chan_o), 64'(rch));
            check("rand_ovf", 64'(bus.Ovf_o), 64'(e.ovf));
            check("rand_neg", 64'(bus.Neg_o), 64'(e.neg));
            settle();
        end

        // Capture on the displayed channel mid-SHIFT: old result first, then the new one.
        bus.Sel_i           = '0;
        bus.Data_i[0 +: DW] = 32'd500;
        bus.Valid_i         = 3'b001;
        step();
        bus.Valid_i = '0;
        repeat (6) step();
        check("mid_busy", 64'(bus.Busy_o), 1);
        bus.Data_i[0 +: DW] = 32'd77;
        bus.Valid_i         = 3'b001;
        hold_m[0]           = 32'd77;
        step();
        bus.Valid_i = '0;
        wait_valid(LAT + 8, got, cyc);
        check("mid_first_valid", 64'(got), 1);
        check("mid_first_bcd", 64'(bus.Bcd_o), 64'(32'h0000_0500));
        wait_valid(LAT + 8, got, cyc);
        check("mid_second_valid", 64'(got), 1);
        check("mid_second_gap", 64'(cyc), 64'(LAT + 1));
        check("mid_second_bcd", 64'(bus.Bcd_o), 64'(32'h0000_0077));
        settle();

        // Reset in the middle of a conversion.
        do_conv("pre_rst", 1, 32'd1234, got);
        settle();
        bus.Data_i[DW +: DW] = 32'd5678;
        bus.Valid_i          = 3'b010;
        step();
        bus.Valid_i = '0;
        repeat (6) step();
        rst = 1'b1;
        step();
        check("abort_busy", 64'(bus.Busy_o), 0);
        check("abort_bcd", 64'(bus.Bcd_o), 0);
        check("abort_chan", 64'(bus.Chan_o), 0);
        rst       = 1'b0;
        bus.Sel_i = '0;
        for (int k = 0; k < NCH; k++) hold_m[k] = '0;
        wait_valid(LAT + 8, got, cyc);
        check("abort_reconv_valid", 64'(got), 1);
        check("abort_reconv_bcd", 64'(bus.Bcd_o), 0);
        settle();

        // Auto-scroll: load distinct values, finish on channel 0, then 12 ticks.
        do_conv("ld1", 1, 32'd111, got);
        do_conv("ld2", 2, 32'd2222, got);
        do_conv("ld0", 0, 32'd30, got);
        settle();
        bus.Mode_i = 1'b1;
        step();
        for (int t = 1; t <= 12; t++) begin
            bus.Tick_i = 1'b1;
            step();
            bus.Tick_i = 1'b0;
            count_valids(LAT + 8, n, ch_seen, bcd_seen);
            if (t % ST == 0) begin
                exp_ch = (t / ST) % NCH;
                e      = model(hold_m[exp_ch], 8);
                check($sformatf("scroll_t%0d_count", t), 64'(n), 1);
                check($sformatf("scroll_t%0d_chan", t), 64'(ch_seen), 64'(exp_ch));
                check($sformatf("scroll_t%0d_bcd", t), 64'(bcd_seen), 64'(e.bcd));
            end else begin
                check($sformatf("scroll_t%0d_count", t), 64'(n), 0);
            end
        end

        // A mode toggle after two ticks restarts the tick count.
        for (int t = 1; t <= 6; t++) begin
            if (t == 3) begin
                bus.Mode_i = 1'b0;
                step();
                bus.Mode_i = 1'b1;
                step();
            end
            bus.Tick_i = 1'b1;
            step();
            bus.Tick_i = 1'b0;
            count_valids(LAT + 8, n, ch_seen, bcd_seen);
            check($sformatf("mode_clr_t%0d_count", t), 64'(n), 64'(t == 6));
            if (t == 6) check("mode_clr_chan", 64'(ch_seen), 1);
        end
        bus.Mode_i = 1'b0;

        // Four-digit instance: overflow saturation and the boundary around 9999.
        conv4(32'd12345, 16'h9999, 1'b1);
        conv4(32'd9999,  16'h9999, 1'b0);
        conv4(32'd10000, 16'h9999, 1'b1);
        conv4(32'd805,   16'h0805, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
